blob_centroid_detect: RTL

- Consumes the camera pixel stream from the capture FIFO.
  - bit16 = 1 is the frame marker, value 17'h10000.
  - bit16 = 0 carries an RGB565 pixel.
- Thresholds each pixel against a target colour and accumulates the x/y sums and count of matching pixels.
- At each frame marker, a sequential divider computes the centroid.
- Drives X_detect/Y_detect/xy_valid into the VGA overlay stage.

---
 rtl/blob_centroid_detect.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/blob_centroid_detect.sv
// Colour-threshold blob detector: accumulates matching-pixel coordinates per frame and
// divides at each frame marker. Optional CENTROID_SMOOTH_EN averages successive centroids.
module blob_centroid_detect #(
    parameter int         IMG_W       = 320,
    parameter int         IMG_H       = 240,
    parameter logic [4:0] R_MIN       = 5'd20,
    parameter logic [5:0] G_MAX       = 6'd24,
    parameter logic [4:0] B_MAX       = 5'd12,
    parameter int         MIN_PIXELS  = 64,
    parameter int         SCALE_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [10:0] X_detect,
    output logic [9:0]  Y_detect,
    output logic        xy_valid,
    output logic        busy
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H + 1);

    typedef enum logic [1:0] {ACCUM, DIVIDE, UPDATE} state_t;

    state_t        state;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [24:0]   sum_x, sum_y;
    logic [16:0]   count;
    logic [24:0]   qx, qy;
    logic [16:0]   rx, ry, divisor;
    logic [4:0]    step;
    logic          frame_ok;
    logic          accept, pix_match;
    logic [10:0]   x_new, x_next;
    logic [9:0]    y_new, y_next;

    // One restoring-division step: shift the next dividend bit into the remainder,
    // subtract when possible, and shift the quotient bit into the dividend register.
    function automatic logic [41:0] div_step(input logic [16:0] rem, input logic [24:0] q,
                                             input logic [16:0] d);
        logic [17:0] t;
        t = {rem, q[24]};
        if (t >= {1'b0, d})
            div_step = {17'(t - {1'b0, d}), q[23:0], 1'b1};
        else
            div_step = {t[16:0], q[23:0], 1'b0};
    endfunction

    assign fifo_rd_en = ~rst & ~fifo_empty & (state == ACCUM);
    assign accept     = fifo_rd_en & ~fifo_empty;
    assign pix_match  = (fifo_dout[15:11] >= R_MIN) & (fifo_dout[10:5] <= G_MAX)
                      & (fifo_dout[4:0] <= B_MAX);

    assign x_new = 11'(qx << SCALE_SHIFT);
    assign y_new = 10'(qy << SCALE_SHIFT);

`ifdef CENTROID_SMOOTH_EN
    logic [11:0] x_sum;
    logic [10:0] y_sum;
    assign x_sum  = {1'b0, X_detect} + {1'b0, x_new};
    assign y_sum  = {1'b0, Y_detect} + {1'b0, y_new};
    assign x_next = xy_valid ? 11'(x_sum >> 1) : x_new;
    assign y_next = xy_valid ? 10'(y_sum >> 1) : y_new;
`else
    assign x_next = x_new;
    assign y_next = y_new;
`endif

    // NOTE: all state below is updated with non-blocking assignments so every register
    // samples pre-edge values, e.g. the marker latches sum_x before it is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACCUM;
            x_cnt    <= '0;
            y_cnt    <= '0;
            sum_x    <= '0;
            sum_y    <= '0;
            count    <= '0;
            qx       <= '0;
            qy       <= '0;
            rx       <= '0;
            ry       <= '0;
            divisor  <= '0;
            step     <= '0;
            frame_ok <= 1'b0;
            X_detect <= '0;
            Y_detect <= '0;
            xy_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        if (fifo_dout[16]) begin
                            qx      <= sum_x;
                            qy      <= sum_y;
                            divisor <= count;
                            rx      <= '0;
                            ry      <= '0;
                            step    <= '0;
                            sum_x   <= '0;
                            sum_y   <= '0;
                            count   <= '0;
                            x_cnt   <= '0;
                            y_cnt   <= '0;
                            if (count < 17'(MIN_PIXELS)) begin
                                frame_ok <= 1'b0;
                                state    <= UPDATE;
                            end else begin
                                frame_ok <= 1'b1;
                                busy     <= 1'b1;
                                state    <= DIVIDE;
                            end
                        end else if (y_cnt != YW'(IMG_H)) begin
                            // Pixels beyond the last line of an overlong frame are dropped.
                            if (pix_match) begin
                                sum_x <= sum_x + 25'(x_cnt);
                                sum_y <= sum_y + 25'(y_cnt);
                                if (count != '1)
                                    count <= count + 17'(1);
                            end
                            if (x_cnt == XW'(IMG_W - 1)) begin
                                x_cnt <= '0;
                                y_cnt <= y_cnt + YW'(1);
                            end else begin
                                x_cnt <= x_cnt + XW'(1);
                            end
                        end
                    end
                end
                DIVIDE: begin
                    {rx, qx} <= div_step(rx, qx, divisor);
                    {ry, qy} <= div_step(ry, qy, divisor);
                    step     <= step + 5'(1);
                    if (step == 5'd24)
                        state <= UPDATE;
                end
                UPDATE: begin
                    if (frame_ok) begin
                        X_detect <= x_next;
                        Y_detect <= y_next;
                        xy_valid <= 1'b1;
                    end else begin
                        xy_valid <= 1'b0;
                    end
                    busy  <= 1'b0;
                    state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule
